// File: rtl/vc_input_buffer_pkg.sv
// Shared router types: flit type encoding, flit record and per-VC packet state.
package vc_input_buffer_pkg;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    localparam int unsigned FlitDataW = 64;

    typedef struct packed {
        flit_type_t             ftype;
        logic [FlitDataW-1:0]   data;
    } flit_t;

    typedef enum logic {
        StIdle,
        StActive
    } pkt_state_e;

endpackage

// File: rtl/vc_fifo.sv
// Single-VC circular FIFO. Pushes into a full FIFO are dropped; the head entry is
// presented combinationally so the owner can register it on a pop.
module vc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             not_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full      = (count_q == (PtrW + 1)'(DEPTH));
    assign not_empty = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];

    // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
    assign do_push = push & ~full;
    assign do_pop  = pop & not_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input buffer: one FIFO per virtual channel, per-VC packet tracking that drives
// the arbiter hold lines, and a registered dequeue port with matching credit return.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int unsigned NUM_VC      = 4,
    parameter int unsigned VC_DEPTH    = 4,
    parameter int unsigned FLIT_DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_in_valid,
    input  logic [$clog2(NUM_VC)-1:0]  flit_in_vc,
    input  flit_type_t                 flit_in_type,
    input  logic [FLIT_DATA_W-1:0]     flit_in_data,
    input  logic [NUM_VC-1:0]          grant_oh,
    output logic [NUM_VC-1:0]          request,
    output logic [NUM_VC-1:0]          hold,
    output logic                       flit_out_valid,
    output logic [$clog2(NUM_VC)-1:0]  flit_out_vc,
    output flit_type_t                 flit_out_type,
    output logic [FLIT_DATA_W-1:0]     flit_out_data,
    output logic [NUM_VC-1:0]          credit_out,
    output logic                       overflow_err
);

    localparam int unsigned VcW    = $clog2(NUM_VC);
    localparam int unsigned EntryW = FLIT_DATA_W + 2;

    logic [NUM_VC-1:0]      push_vec, full_vec, gnt_sel, pop_vec;
    logic [EntryW-1:0]      head_data [NUM_VC];
    logic [EntryW-1:0]      pop_entry;
    logic [VcW-1:0]         pop_vc;
    flit_type_t             pop_type;
    logic                   pop_any;
    pkt_state_e             state_q [NUM_VC];
    pkt_state_e             state_d [NUM_VC];

    logic                   out_valid_q;
    logic [VcW-1:0]         out_vc_q;
    flit_type_t             out_type_q;
    logic [FLIT_DATA_W-1:0] out_data_q;
    logic [NUM_VC-1:0]      credit_q;
    logic                   overflow_q, overflow_d;

    always_comb begin
        push_vec = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_vec[v] = flit_in_valid && (flit_in_vc == VcW'(v));
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(
            .DEPTH (VC_DEPTH),
            .WIDTH (EntryW)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_vec[v]),
            .push_data ({flit_in_type, flit_in_data}),
            .pop       (pop_vec[v]),
            .head_data (head_data[v]),
            .full      (full_vec[v]),
            .not_empty (request[v])
        );
    end

    // An illegal multi-hot grant is reduced to its lowest set bit; grants to empty VCs vanish.
    assign gnt_sel = grant_oh & (~grant_oh + 1'b1);
    assign pop_vec = gnt_sel & request;
    assign pop_any = |pop_vec;

    always_comb begin
        pop_entry = '0;
        pop_vc    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (pop_vec[v]) begin
                pop_entry = head_data[v];
                pop_vc    = VcW'(v);
            end
        end
    end

    assign pop_type = flit_type_t'(pop_entry[EntryW-1 -: 2]);

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v] = state_q[v];
            if (pop_vec[v]) begin
                case (pop_type)
                    HEAD:    state_d[v] = StActive;
                    TAIL:    state_d[v] = StIdle;
                    default: state_d[v] = state_q[v];
                endcase
            end
        end
    end

    always_comb begin
        hold = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            hold[v] = (state_q[v] == StActive) && request[v];
        end
    end

    assign overflow_d = overflow_q | (flit_in_valid & |(push_vec & full_vec));

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_type_q  <= HEAD;
            out_data_q  <= '0;
            credit_q    <= '0;
            overflow_q  <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= StIdle;
            end
        end else begin
            out_valid_q <= pop_any;
            credit_q    <= pop_vec;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            if (pop_any) begin
                out_vc_q   <= pop_vc;
                out_type_q <= pop_type;
                out_data_q <= pop_entry[FLIT_DATA_W-1:0];
            end
        end
    end

    assign flit_out_valid = out_valid_q;
    assign flit_out_vc    = out_vc_q;
    assign flit_out_type  = out_type_q;
    assign flit_out_data  = out_data_q;
    assign credit_out     = credit_q;
    assign overflow_err   = overflow_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh))
        else $error("grant_oh is not one-hot");

endmodule
